axilite_mmio_slave: RTL and testbench
=====================================

AXILITE_MMIO_SLAVE -- requirements
Module: axilite_mmio_slave

Interface
REQ-001 SHALL have parameter ID_VALUE, default 32'h4C56_4E41, the constant returned by the ID register.
REQ-002 SHALL have parameter LED_WIDTH, default 7, the width of the LED output register.
REQ-003 SHALL have ports `uncoreclk` (in, 1, sole clock) and `uncore_rstn` (in, 1, reset); one clock, reset asynchronous and active-low.
REQ-004 SHALL have AW channel ports `s_axilite_awaddr` (in, 32), `s_axilite_awvalid` (in, 1) and `s_axilite_awready` (out, 1).
REQ-005 SHALL have W channel ports `s_axilite_wdata` (in, 32), `s_axilite_wstrb` (in, 4), `s_axilite_wvalid` (in, 1) and `s_axilite_wready` (out, 1).
REQ-006 SHALL have B channel ports `s_axilite_bresp` (out, 2), `s_axilite_bvalid` (out, 1) and `s_axilite_bready` (in, 1).
REQ-007 SHALL have AR channel ports `s_axilite_araddr` (in, 32), `s_axilite_arvalid` (in, 1) and `s_axilite_arready` (out, 1).
REQ-008 SHALL have R channel ports `s_axilite_rdata` (out, 32), `s_axilite_rresp` (out, 2), `s_axilite_rvalid` (out, 1) and `s_axilite_rready` (in, 1).
REQ-009 SHALL have `intrs` (in, 2): DMA interrupt levels, synchronous to `uncoreclk`; `led` (out, LED_WIDTH): LED register value; `irq` (out, 1): combined interrupt to core.

Function
REQ-010 SHALL decode address bits [4:2] only; map: 0x00 LED rw; 0x04 SCRATCH rw; 0x08 CYCLE_LO ro; 0x0C CYCLE_HI ro; 0x10 INTR_STATUS rw1c; 0x14 INTR_ENABLE rw; 0x18 ID ro; 0x1C unmapped.
REQ-011 SHALL apply `wstrb` per byte on LED, SCRATCH and INTR_ENABLE; bits above a register's width SHALL read 0.
REQ-012 SHALL run the write FSM through W_IDLE -> W_GOTADDR (AW taken, W pending) or W_GOTDATA (W taken, AW pending) or straight to W_RESP (both same cycle) -> W_IDLE on `bvalid`&`bready`.
REQ-013 SHALL assert `awready` only in W_IDLE/W_GOTDATA and `wready` only in W_IDLE/W_GOTADDR; one write outstanding.
REQ-014 SHALL commit the register write on the cycle the FSM enters W_RESP; `bvalid` SHALL rise the following cycle (1-cycle latency from last handshake).
REQ-015 SHALL give `bresp`=OKAY(00) for mapped writable offsets, SLVERR(10) for ro offsets and 0x1C, with no state change on SLVERR.
REQ-016 SHALL run the read FSM R_IDLE -> R_RESP on `arvalid`&`arready`, with `arready`=1 only in R_IDLE, and `rdata`/`rresp` registered at AR handshake and held stable until `rready`.
REQ-017 SHALL give `rresp`=SLVERR with `rdata`=0 for 0x1C, otherwise OKAY.
REQ-018 SHALL run a 64-bit cycle counter that increments every cycle and wraps from all-ones to 0.
REQ-019 SHALL, on a CYCLE_LO read, return counter[31:0] and latch counter[63:32] into a shadow; CYCLE_HI SHALL return the shadow.
REQ-020 SHALL set INTR_STATUS[i] on a 0->1 edge of `intrs[i]`; write-1 SHALL clear it; on set and clear in the same cycle, set wins.
REQ-021 SHALL drive `irq` = |(INTR_STATUS & INTR_ENABLE[1:0]) from registers (no input-to-output path).
REQ-022 SHALL run read and write FSMs independently; a read handshaking in the commit cycle of a write to the same register SHALL return the pre-write value.
REQ-023 SHALL keep B and R channels non-blocking to each other; backpressure on one SHALL NOT stall the other.

Reset
REQ-024 SHALL, while `uncore_rstn`=0, drive all ready/valid outputs, `bresp`, `rresp`, `rdata`, `led` and `irq` to 0 and clear all registers, the counter, the shadow and the edge history.
REQ-025 SHALL abandon any in-flight transaction on reset assertion mid-operation; no response SHALL be issued after deassertion.
REQ-026 SHALL assert `awready`/`wready`/`arready` on the first clock edge after deassertion.

Structure
REQ-027 SHALL place register offsets, RESP codes (OKAY, SLVERR) and FSM state enums in shared package axilite_mmio_pkg.
REQ-028 SHALL implement edge detection plus the set/clear status bits in one sub-module, intr_capture, instantiated once with width 2.

Verification
REQ-029 SHALL cover: AW and W same cycle, addr 0x04, data 0xDEADBEEF, strb 0xF -> `bvalid` next cycle, OKAY; read 0x04 -> 0xDEADBEEF, OKAY.
REQ-030 SHALL cover: W 3 cycles before AW to 0x00, data 0xFF, strb 0x1 -> `led`=7'h7F, OKAY; then strb 0x0 data 0 -> `led` unchanged.
REQ-031 SHALL cover: write 0x18 and read 0x1C -> both SLVERR, `rdata`=0, ID still reads ID_VALUE.
REQ-032 SHALL cover: counter forced to 0x0000_0000_FFFF_FFFE, read LO then HI 3 cycles later -> LO 0xFFFF_FFFE+k, HI 0 (shadow, not 1).
REQ-033 SHALL cover: ENABLE=0x3, `intrs` 00->01 -> STATUS=0x1, `irq`=1; W1C 0x1 coinciding with new edge -> STATUS stays 0x1.
REQ-034 SHALL cover: `bready`=0 for 10 cycles while reads to 0x18 complete -> reads unaffected; reset asserted with `bvalid` high -> `bvalid` 0, no B after reset.

Source files
------------

// File: rtl/axilite_mmio_pkg.sv
// Shared definitions for the AXI4-Lite MMIO slave.
// Contents:
//   reg_off_t       - register offsets, taken from address bits [4:2]
//   RESP_*          - AXI response codes
//   wr_state_t      - write-channel FSM states
//   rd_state_t      - read-channel FSM states
//   fsm_dbg_t       - both FSM states bundled for observation
//   is_writable()   - offsets that accept writes (everything else is SLVERR)
//   merge_strb()    - per-byte write-strobe merge
package axilite_mmio_pkg;

  typedef enum logic [2:0] {
    REG_LED         = 3'd0,  // 0x00 rw
    REG_SCRATCH     = 3'd1,  // 0x04 rw
    REG_CYCLE_LO    = 3'd2,  // 0x08 ro
    REG_CYCLE_HI    = 3'd3,  // 0x0C ro (shadow)
    REG_INTR_STATUS = 3'd4,  // 0x10 rw1c
    REG_INTR_ENABLE = 3'd5,  // 0x14 rw
    REG_ID          = 3'd6,  // 0x18 ro
    REG_UNMAPPED    = 3'd7   // 0x1C
  } reg_off_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int INTR_WIDTH = 2;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_GOTADDR = 2'd1,
    W_GOTDATA = 2'd2,
    W_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } rd_state_t;

  typedef struct packed {
    wr_state_t wr_state;
    rd_state_t rd_state;
  } fsm_dbg_t;

  function automatic logic is_writable(input reg_off_t off);
    return (off == REG_LED) || (off == REG_SCRATCH) ||
           (off == REG_INTR_STATUS) || (off == REG_INTR_ENABLE);
  endfunction

  function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axilite_mmio_slave_intr_capture.sv
// Rising-edge interrupt capture with sticky, write-1-to-clear status bits.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   level       - interrupt levels, synchronous to clk
//   clr         - one-cycle clear mask (write-1-to-clear pulse)
//   status      - sticky status, one bit per source
// A new rising edge in the same cycle as a clear keeps the bit set.
module intr_capture #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] level,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] status
);

  logic [WIDTH-1:0] level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
      status  <= '0;
    end else begin
      level_q <= level;
      status  <= (status & ~clr) | (level & ~level_q);
    end
  end

endmodule

// File: rtl/axilite_mmio_slave.sv
// AXI4-Lite MMIO slave: LED, scratch, 64-bit cycle counter, interrupt
// status/enable and a constant ID register.
// Ports:
//   uncoreclk, uncore_rstn     - clock, asynchronous active-low reset
//   s_axilite_aw*/w*/b*/ar*/r* - AXI4-Lite slave channels
//   intrs                      - DMA interrupt levels (synchronous)
//   led                        - LED register value
//   irq                        - OR of enabled, pending status bits
//   fsm_dbg                    - current write/read FSM states
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid, once raised by this slave, stays high with stable
// payload until the matching ready is seen. All readies are registered.
// Only address bits [4:2] are decoded.
module axilite_mmio_slave
  import axilite_mmio_pkg::*;
#(
  parameter logic [31:0] ID_VALUE  = 32'h4C56_4E41,
  parameter int          LED_WIDTH = 7   // must not exceed 32
) (
  input  logic                 uncoreclk,
  input  logic                 uncore_rstn,
  input  logic [31:0]          s_axilite_awaddr,
  input  logic                 s_axilite_awvalid,
  output logic                 s_axilite_awready,
  input  logic [31:0]          s_axilite_wdata,
  input  logic [3:0]           s_axilite_wstrb,
  input  logic                 s_axilite_wvalid,
  output logic                 s_axilite_wready,
  output logic [1:0]           s_axilite_bresp,
  output logic                 s_axilite_bvalid,
  input  logic                 s_axilite_bready,
  input  logic [31:0]          s_axilite_araddr,
  input  logic                 s_axilite_arvalid,
  output logic                 s_axilite_arready,
  output logic [31:0]          s_axilite_rdata,
  output logic [1:0]           s_axilite_rresp,
  output logic                 s_axilite_rvalid,
  input  logic                 s_axilite_rready,
  input  logic [1:0]           intrs,
  output logic [LED_WIDTH-1:0] led,
  output logic                 irq,
  output fsm_dbg_t             fsm_dbg
);

  wr_state_t             wr_state;
  rd_state_t             rd_state;
  reg_off_t              aw_off_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  aw_hs, w_hs, ar_hs;
  logic                  wr_commit, wr_ok, wr_en;
  reg_off_t              wr_off, ar_off;
  logic [31:0]           wr_data;
  logic [3:0]            wr_strb;
  logic [LED_WIDTH-1:0]  led_q;
  logic [31:0]           scratch_q;
  logic [1:0]            intr_en_q;
  logic [1:0]            intr_status;
  logic [1:0]            intr_clr;
  logic [63:0]           cycle_cnt;
  logic [31:0]           cycle_hi_shadow;
  logic [31:0]           rd_mux;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{s_axilite_awaddr[31:5], s_axilite_awaddr[1:0],
                              s_axilite_araddr[31:5], s_axilite_araddr[1:0]};

  assign aw_hs  = s_axilite_awvalid && s_axilite_awready;
  assign w_hs   = s_axilite_wvalid  && s_axilite_wready;
  assign ar_hs  = s_axilite_arvalid && s_axilite_arready;
  assign ar_off = reg_off_t'(s_axilite_araddr[4:2]);

  assign fsm_dbg = '{wr_state: wr_state, rd_state: rd_state};

  // The write commits on the edge that completes the second of the AW/W
  // handshakes; whichever half arrived earlier comes from its holding reg.
  always_comb begin
    wr_commit = 1'b0;
    wr_off    = reg_off_t'(s_axilite_awaddr[4:2]);
    wr_data   = s_axilite_wdata;
    wr_strb   = s_axilite_wstrb;
    case (wr_state)
      W_IDLE:    wr_commit = aw_hs && w_hs;
      W_GOTADDR: begin
        wr_commit = w_hs;
        wr_off    = aw_off_q;
      end
      W_GOTDATA: begin
        wr_commit = aw_hs;
        wr_data   = wdata_q;
        wr_strb   = wstrb_q;
      end
      default: ;
    endcase
  end

  assign wr_ok    = is_writable(wr_off);
  assign wr_en    = wr_commit && wr_ok;
  assign intr_clr = (wr_en && (wr_off == REG_INTR_STATUS) && wr_strb[0]) ?
                    wr_data[1:0] : 2'b00;

  // Write FSM
  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      wr_state          <= W_IDLE;
      s_axilite_awready <= 1'b0;
      s_axilite_wready  <= 1'b0;
      s_axilite_bvalid  <= 1'b0;
      s_axilite_bresp   <= RESP_OKAY;
      aw_off_q          <= REG_LED;
      wdata_q           <= '0;
      wstrb_q           <= '0;
    end else if (wr_commit) begin
      wr_state          <= W_RESP;
      s_axilite_awready <= 1'b0;
      s_axilite_wready  <= 1'b0;
      s_axilite_bvalid  <= 1'b1;
      s_axilite_bresp   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            wr_state          <= W_GOTADDR;
            aw_off_q          <= reg_off_t'(s_axilite_awaddr[4:2]);
            s_axilite_awready <= 1'b0;
            s_axilite_wready  <= 1'b1;
          end else if (w_hs) begin
            wr_state          <= W_GOTDATA;
            wdata_q           <= s_axilite_wdata;
            wstrb_q           <= s_axilite_wstrb;
            s_axilite_awready <= 1'b1;
            s_axilite_wready  <= 1'b0;
          end else begin
            // also raises the readies on the first edge out of reset
            s_axilite_awready <= 1'b1;
            s_axilite_wready  <= 1'b1;
          end
        end
        W_RESP: begin
          if (s_axilite_bready) begin
            wr_state          <= W_IDLE;
            s_axilite_bvalid  <= 1'b0;
            s_axilite_awready <= 1'b1;
            s_axilite_wready  <= 1'b1;
          end
        end
        default: ;  // W_GOTADDR / W_GOTDATA wait for the other half
      endcase
    end
  end

  // Writable registers; reads in the commit cycle still see the old value.
  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      led_q     <= '0;
      scratch_q <= '0;
      intr_en_q <= '0;
    end else if (wr_en) begin
      case (wr_off)
        REG_LED:         led_q     <= LED_WIDTH'(merge_strb(32'(led_q), wr_data, wr_strb));
        REG_SCRATCH:     scratch_q <= merge_strb(scratch_q, wr_data, wr_strb);
        REG_INTR_ENABLE: intr_en_q <= 2'(merge_strb(32'(intr_en_q), wr_data, wr_strb));
        default: ;
      endcase
    end
  end

  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) cycle_cnt <= '0;
    else              cycle_cnt <= cycle_cnt + 64'd1;
  end

  always_comb begin
    rd_mux = '0;
    case (ar_off)
      REG_LED:         rd_mux = 32'(led_q);
      REG_SCRATCH:     rd_mux = scratch_q;
      REG_CYCLE_LO:    rd_mux = cycle_cnt[31:0];
      REG_CYCLE_HI:    rd_mux = cycle_hi_shadow;
      REG_INTR_STATUS: rd_mux = 32'(intr_status);
      REG_INTR_ENABLE: rd_mux = 32'(intr_en_q);
      REG_ID:          rd_mux = ID_VALUE;
      default:         rd_mux = '0;
    endcase
  end

  // Read FSM. Reading CYCLE_LO snapshots the upper counter half so a
  // following CYCLE_HI read is coherent with it.
  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      rd_state          <= R_IDLE;
      s_axilite_arready <= 1'b0;
      s_axilite_rvalid  <= 1'b0;
      s_axilite_rdata   <= '0;
      s_axilite_rresp   <= RESP_OKAY;
      cycle_hi_shadow   <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            rd_state          <= R_RESP;
            s_axilite_arready <= 1'b0;
            s_axilite_rvalid  <= 1'b1;
            s_axilite_rdata   <= rd_mux;
            s_axilite_rresp   <= (ar_off == REG_UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
            if (ar_off == REG_CYCLE_LO) cycle_hi_shadow <= cycle_cnt[63:32];
          end else begin
            s_axilite_arready <= 1'b1;
          end
        end
        R_RESP: begin
          if (s_axilite_rready) begin
            rd_state          <= R_IDLE;
            s_axilite_rvalid  <= 1'b0;
            s_axilite_arready <= 1'b1;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  intr_capture #(
    .WIDTH (INTR_WIDTH)
  ) u_intr_capture (
    .clk    (uncoreclk),
    .rst_n  (uncore_rstn),
    .level  (intrs),
    .clr    (intr_clr),
    .status (intr_status)
  );

  assign led = led_q;
  assign irq = |(intr_status & intr_en_q);

endmodule

// File: tb/tb_axilite_mmio_slave.sv
// Directed + randomized bench for axilite_mmio_slave with a register-level
// reference model and an expected-read queue.
module tb_axilite_mmio_slave;

  localparam logic [31:0] ID_VALUE  = 32'h4C56_4E41;
  localparam int          LED_WIDTH = 7;
  localparam logic [31:0] LED_MASK  = 32'h0000_007F;
  localparam logic [1:0]  OKAY      = 2'b00;
  localparam logic [1:0]  SLVERR    = 2'b10;

  // ---------------- clock / reset ----------------
  logic uncoreclk = 1'b0;
  logic uncore_rstn = 1'b0;
  always #5 uncoreclk = ~uncoreclk;

  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic awvalid = 0, wvalid = 0, arvalid = 0, bready = 1, rready = 1;
  logic awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [1:0]  intrs = 2'b00;
  logic [LED_WIDTH-1:0] led;
  logic [2:0]  fsm_dbg_unused;

  axilite_mmio_slave #(.ID_VALUE(ID_VALUE), .LED_WIDTH(LED_WIDTH)) dut (
    .uncoreclk         (uncoreclk),
    .uncore_rstn       (uncore_rstn),
    .s_axilite_awaddr  (awaddr),
    .s_axilite_awvalid (awvalid),
    .s_axilite_awready (awready),
    .s_axilite_wdata   (wdata),
    .s_axilite_wstrb   (wstrb),
    .s_axilite_wvalid  (wvalid),
    .s_axilite_wready  (wready),
    .s_axilite_bresp   (bresp),
    .s_axilite_bvalid  (bvalid),
    .s_axilite_bready  (bready),
    .s_axilite_araddr  (araddr),
    .s_axilite_arvalid (arvalid),
    .s_axilite_arready (arready),
    .s_axilite_rdata   (rdata),
    .s_axilite_rresp   (rresp),
    .s_axilite_rvalid  (rvalid),
    .s_axilite_rready  (rready),
    .intrs             (intrs),
    .led               (led),
    .irq               (irq),
    .fsm_dbg           (fsm_dbg_unused)
  );

  // ---------------- reference model ----------------
  int tests = 0;
  int failed = 0;
  logic [31:0] m_led = '0, m_scratch = '0, m_en = '0, m_status = '0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] byte_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [1:0] model_wresp(input int off);
    return (off == 0 || off == 1 || off == 4 || off == 5) ? OKAY : SLVERR;
  endfunction

  function automatic void model_write(input int off, input logic [31:0] d, input logic [3:0] s);
    case (off)
      0: m_led     = byte_merge(m_led, d, s) & LED_MASK;
      1: m_scratch = byte_merge(m_scratch, d, s);
      4: if (s[0]) m_status = m_status & ~(d & 32'h3);
      5: m_en      = byte_merge(m_en, d, s) & 32'h3;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input int off);
    case (off)
      0: return m_led;
      1: return m_scratch;
      4: return m_status;
      5: return m_en;
      6: return ID_VALUE;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_delay, input int w_delay,
                           input bit wait_b, output logic [1:0] resp);
    int cyc = 0;
    bit aw_pend = 1, w_pend = 1, aw_fire, w_fire;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = (aw_delay == 0);
    wvalid  = (w_delay == 0);
    while ((aw_pend || w_pend) && cyc < 40) begin
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(negedge uncoreclk); cyc++;
      if (aw_fire) begin aw_pend = 0; awvalid = 0; end
      if (w_fire)  begin w_pend = 0;  wvalid = 0;  end
      if (aw_pend && cyc >= aw_delay) awvalid = 1;
      if (w_pend && cyc >= w_delay)   wvalid = 1;
    end
    awvalid = 0; wvalid = 0;
    check("aw_w_accepted", {aw_pend, w_pend}, 2'b00);
    check("bvalid_one_cycle", bvalid, 1'b1);
    resp = bresp;
    if (wait_b) begin
      @(negedge uncoreclk);
      check("bvalid_cleared", bvalid, 1'b0);
    end
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp);
    int cyc = 0;
    araddr = addr; arvalid = 1;
    while (!arready && cyc < 40) begin @(negedge uncoreclk); cyc++; end
    @(negedge uncoreclk);
    arvalid = 0;
    cyc = 0;
    while (!rvalid && cyc < 40) begin @(negedge uncoreclk); cyc++; end
    check("rvalid_seen", rvalid, 1'b1);
    data = rdata; resp = rresp;
    @(negedge uncoreclk);
  endtask

  task automatic read_check(input string tag, input logic [31:0] addr);
    int off;
    logic [31:0] d, e;
    logic [1:0] r;
    off = int'(addr[4:2]);
    exp_q.push_back(model_read(off));
    axi_read(addr, d, r);
    e = exp_q.pop_front();
    check(tag, d, e);
    check({tag, "_resp"}, r, (off == 7) ? SLVERR : OKAY);
  endtask

  task automatic write_check(input string tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_delay, input int w_delay);
    logic [1:0] r;
    int off;
    off = int'(addr[4:2]);
    axi_write(addr, data, strb, aw_delay, w_delay, 1, r);
    check(tag, r, model_wresp(off));
    model_write(off, data, strb);
    check({tag, "_led"}, led, m_led);
  endtask

  task automatic reset_outputs_check(input string tag);
    check({tag, "_readies"}, {awready, wready, arready}, 3'b000);
    check({tag, "_valids"}, {bvalid, rvalid}, 2'b00);
    check({tag, "_resps"}, {bresp, rresp}, 4'b0000);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_led_irq"}, {led, irq}, 8'h00);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d, old, addr;
    logic [1:0]  r;
    int off;

    // reset state
    repeat (3) @(negedge uncoreclk);
    reset_outputs_check("reset");
    uncore_rstn = 1;
    check("ready_before_first_edge", {awready, wready, arready}, 3'b000);
    @(negedge uncoreclk);
    check("ready_after_first_edge", {awready, wready, arready}, 3'b111);

    // AW+W same cycle to scratch, then read back
    write_check("scratch_wr", 32'h04, 32'hDEAD_BEEF, 4'hF, 0, 0);
    read_check("scratch_rd", 32'h04);

    // W three cycles ahead of AW to LED, then an all-zero strobe write
    write_check("led_wr_w_first", 32'h00, 32'h0000_00FF, 4'h1, 3, 0);
    check("led_7f", led, 7'h7F);
    write_check("led_wr_nostrb", 32'h00, 32'h0, 4'h0, 0, 0);
    check("led_unchanged", led, 7'h7F);

    // read-only / unmapped
    write_check("id_wr_slverr", 32'h18, 32'h1234_5678, 4'hF, 0, 0);
    read_check("unmapped_rd", 32'h1C);
    read_check("id_rd", 32'h18);

    // read handshaking on the write's commit edge sees the old value
    old = m_scratch;
    awaddr = 32'h04; wdata = 32'hA5A5_0F0F; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    araddr = 32'h04; arvalid = 1;
    check("idle_readies", {awready, wready, arready}, 3'b111);
    @(negedge uncoreclk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    check("same_edge_bvalid", bvalid, 1'b1);
    check("same_edge_rvalid", rvalid, 1'b1);
    check("same_edge_old_data", rdata, old);
    model_write(1, 32'hA5A5_0F0F, 4'hF);
    @(negedge uncoreclk);
    read_check("scratch_new", 32'h04);

    // cycle counter near the 32-bit boundary
    force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFE;
    axi_read(32'h08, d, r);
    check("cycle_lo", d, 32'hFFFF_FFFE);
    check("cycle_lo_resp", r, OKAY);
    release dut.cycle_cnt;
    repeat (3) @(negedge uncoreclk);
    axi_read(32'h0C, d, r);
    check("cycle_hi_shadow", d, 32'h0);
    axi_read(32'h08, d, r);
    check("cycle_lo_wrapped", (d < 32'd64), 1'b1);
    axi_read(32'h0C, d, r);
    check("cycle_hi_after_wrap", d, 32'h1);

    // interrupts
    write_check("en_wr", 32'h14, 32'h3, 4'hF, 0, 0);
    intrs = 2'b01;
    @(negedge uncoreclk);
    m_status = 32'h1;
    check("irq_set", irq, 1'b1);
    read_check("status_set", 32'h10);
    intrs = 2'b00;
    @(negedge uncoreclk);
    intrs = 2'b01;  // new edge on the same edge as the clear commits
    write_check("w1c_vs_edge", 32'h10, 32'h1, 4'hF, 0, 0);
    m_status = m_status | 32'h1;
    read_check("status_set_wins", 32'h10);
    check("irq_still_set", irq, 1'b1);
    write_check("w1c_plain", 32'h10, 32'h1, 4'hF, 0, 0);
    read_check("status_cleared", 32'h10);
    check("irq_cleared", irq, 1'b0);
    write_check("en_off", 32'h14, 32'h0, 4'hF, 0, 0);
    intrs = 2'b11;
    @(negedge uncoreclk);
    m_status = m_status | 32'h2;
    check("irq_masked", irq, 1'b0);
    read_check("status_bit1", 32'h10);
    write_check("en_bit1", 32'h14, 32'h2, 4'hF, 0, 0);
    check("irq_enabled_bit1", irq, 1'b1);
    write_check("w1c_all", 32'h10, 32'h3, 4'hF, 0, 0);
    check("irq_off_again", irq, 1'b0);
    intrs = 2'b00;
    write_check("en_clear", 32'h14, 32'h0, 4'hF, 0, 0);

    // randomized register traffic (upper/lower address bits ignored)
    for (int i = 0; i < 40; i++) begin
      off = $urandom_range(0, 7);
      addr = ($urandom() & 32'hFFFF_FFE0) | (32'(off) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        write_check("rand_wr", addr, $urandom(), 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), $urandom_range(0, 3));
      end else if (off == 2 || off == 3) begin
        axi_read(addr, d, r);
        check("rand_cycle_resp", r, OKAY);
      end else begin
        read_check("rand_rd", addr);
      end
    end

    // B backpressure does not stall reads
    bready = 0;
    axi_write(32'h04, 32'h1234_5678, 4'hF, 0, 0, 0, r);
    check("bp_wr_resp", r, OKAY);
    model_write(1, 32'h1234_5678, 4'hF);
    for (int i = 0; i < 5; i++) begin
      read_check("bp_id_rd", 32'h18);
      check("bp_bvalid_held", bvalid, 1'b1);
      check("bp_awready_low", awready, 1'b0);
    end

    // reset while a B response is pending
    uncore_rstn = 0;
    #1;
    reset_outputs_check("mid_reset");
    m_led = '0; m_scratch = '0; m_en = '0; m_status = '0;
    @(negedge uncoreclk);
    @(negedge uncoreclk);
    uncore_rstn = 1;
    bready = 1;
    check("post_reset_ready_low", awready, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge uncoreclk);
      check("no_b_after_reset", bvalid, 1'b0);
    end
    check("post_reset_ready_high", {awready, wready, arready}, 3'b111);
    read_check("scratch_after_reset", 32'h04);
    read_check("led_after_reset", 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
